branch_unit_ras: RTL and testbench
==================================

Name: branch_unit_ras

Overview:
- Registered, parametrised branch-resolution unit for the KGP_RISC execute stage.
- Evaluates the branch opcode against the ALU flags and produces the next PC, the PC-select and the link address.
- Adds what the combinational branch logic lacks: a valid/ready output register, a flush input, and a circular return-address stack (RAS) that predicts return targets and flags mispredictions.

Parameters:
- XLEN, 32, datapath and PC width.
- JW, 26, jump-address field width; zero-extended to XLEN.
- RAS_DEPTH, 4, return-stack entries; power of 2, at least 2.
- LINK_OFFSET, 4, added to pc_i to form the link address.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- flush_i  in  1  discard the in-flight result and any incoming instruction.
- in_valid_i  in  1  instruction presented.
- in_ready_o  out  1  unit can accept; equals !out_valid_o || out_ready_i.
- opcode_i  in  6  instruction opcode.
- rs_i  in  XLEN  register operand (BR/RET target).
- jaddr_i  in  JW  jump-address field.
- carry_i, zero_i, overflow_i, sign_i  in  1 each  ALU flags.
- pc_i  in  XLEN  address of the branch instruction.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts the result.
- ex_npc_o  out  XLEN  branch target.
- pc_src_o  out  1  1 = taken (select ex_npc_o).
- ra_o  out  XLEN  link value, pc_i + LINK_OFFSET.
- ra_we_o  out  1  write ra_o to the link register (BL only).
- ras_miss_o  out  1  RET popped an empty stack.
- ret_mismatch_o  out  1  RET prediction differed from rs_i.
- ras_count_o  out  $clog2(RAS_DEPTH)+1  current stack occupancy.

Behaviour:
- Opcodes (6-bit):
  - 110000 B: always taken.
  - 110001 BZ: taken if zero.
  - 110010 BNZ: taken if !zero.
  - 110011 BCY: taken if carry.
  - 110100 BNCY: taken if !carry.
  - 110101 BV: taken if overflow.
  - 110110 BS: taken if sign.
  - 110111 BR: always taken, target rs_i.
  - 111001 BL: always taken, target jaddr, pushes link.
  - 111010 RET: always taken, pops the RAS.
  - Any other opcode: pc_src_o=0, ex_npc_o=0, no RAS effect.
- Targets:
  - All jaddr-based branches use target = zero-extended jaddr_i.
  - Adds wrap modulo 2^XLEN.
- Handshake:
  - An accept happens when in_valid_i && in_ready_o && !flush_i.
  - Latency is 1 cycle: outputs register at the accept edge, and out_valid_o rises the next cycle.
  - Outputs hold while out_valid_o && !out_ready_i.
  - out_valid_o clears on out_ready_i when there is no new accept.
- Outputs registered on accept:
  - ra_o is registered for every accepted opcode.
  - ra_we_o=1 only for BL.
  - ras_miss_o and ret_mismatch_o are meaningful only for RET and are 0 otherwise.
- RAS storage: circular array, top pointer, saturating count.
- BL accept: write pc_i+LINK_OFFSET at top+1 and advance top.
  - Count increments, saturating at RAS_DEPTH.
  - When full, the oldest entry is overwritten and count stays at RAS_DEPTH.
- RET accept, count>0:
  - ex_npc_o = top entry.
  - ret_mismatch_o = (top entry != rs_i).
  - Pointer retreats and count decrements.
- RET accept, count=0:
  - ex_npc_o = rs_i, ras_miss_o=1, ret_mismatch_o=0.
  - Count stays 0.
- RAS updates only on accept. A stalled or flushed instruction never touches the stack.
- flush_i:
  - Clears out_valid_o next cycle and blocks the same-cycle accept.
  - RAS contents are kept.
  - flush_i overrides out_ready_i.
- Reset:
  - out_valid_o=0; ex_npc_o, ra_o=0; pc_src_o, ra_we_o, ras_miss_o, ret_mismatch_o=0.
  - RAS pointer and count=0; entries cleared to 0.
  - Reset asserted mid-stall drops the held result.

Decomposition:
- Package branch_pkg holds:
  - the opcode localparams (OP_B … OP_RET);
  - a branch_kind enum {NONE, COND, REG, CALL, RETURN};
  - the condition-select encoding.
- One sub-module, ras_stack:
  - parametrised on XLEN and RAS_DEPTH;
  - ports: push, pop, push_data, top_data, empty, count;
  - handles wrap and saturation internally.
- Decode, condition evaluation and the output register stay in branch_unit_ras.

Test Plan:
1. Flags and condition:
   - Stimulus: opcode 110011, jaddr 0x0CD7C15, carry=1, out_ready_i=1.
   - Response, next cycle: out_valid_o=1, pc_src_o=1, ex_npc_o=0x00CD7C15.
   - Repeat with carry=0: pc_src_o=0.
2. Call then return:
   - Stimulus: BL with pc_i=0x00001000; then RET with rs_i=0x00001004.
   - Response, BL: ra_o=0x00001004, ra_we_o=1, ras_count_o 0→1.
   - Response, RET: ex_npc_o=0x00001004, ret_mismatch_o=0, count→0.
3. Overflow wrap:
   - Stimulus: 5 BLs at pc 0x10, 0x20, 0x30, 0x40, 0x50 (RAS_DEPTH=4); then 5 RETs.
   - Response: count saturates at 4.
   - Response: RETs return 0x54, 0x44, 0x34, 0x24.
   - Response: 5th RET has ras_miss_o=1 and ex_npc_o=rs_i.
4. Mismatch:
   - Stimulus: BL pc=0x200; then RET rs_i=0x300.
   - Response: ex_npc_o=0x204, ret_mismatch_o=1.
5. Stall:
   - Stimulus: hold out_ready_i=0 for 3 cycles after a BZ (zero=1).
   - Response: in_ready_o=0, outputs stable.
   - Response: a BL presented during the stall does not change ras_count_o until accepted.
6. Flush/reset:
   - Stimulus: flush_i together with in_valid_i on a BL.
   - Response: out_valid_o=0 next cycle, ras_count_o unchanged.
   - Stimulus: rst during a held result.
   - Response: every output reads 0 the next cycle.

Source files
------------

// File: rtl/branch_pkg.sv
// ---------------------------------------------------------------------------
// branch_pkg
// Shared definitions for the KGP_RISC branch-resolution unit.
//   - OP_* : 6-bit branch opcodes
//   - branchKind_e : coarse classification of a branch opcode
//   - condSel_e : which ALU flag (and polarity) a conditional branch tests
//   - decodeKind / decodeCond : opcode -> kind / condition helpers
// ---------------------------------------------------------------------------
package branch_pkg;

  localparam logic [5:0] OP_B    = 6'b110000;
  localparam logic [5:0] OP_BZ   = 6'b110001;
  localparam logic [5:0] OP_BNZ  = 6'b110010;
  localparam logic [5:0] OP_BCY  = 6'b110011;
  localparam logic [5:0] OP_BNCY = 6'b110100;
  localparam logic [5:0] OP_BV   = 6'b110101;
  localparam logic [5:0] OP_BS   = 6'b110110;
  localparam logic [5:0] OP_BR   = 6'b110111;
  localparam logic [5:0] OP_BL   = 6'b111001;
  localparam logic [5:0] OP_RET  = 6'b111010;

  typedef enum logic [2:0] {
    NONE,
    COND,
    REG,
    CALL,
    RETURN
  } branchKind_e;

  typedef enum logic [2:0] {
    COND_ALWAYS,
    COND_ZERO,
    COND_NZERO,
    COND_CARRY,
    COND_NCARRY,
    COND_OVF,
    COND_SIGN,
    COND_NEVER
  } condSel_e;

  // Unconditional B is treated as a conditional branch whose condition is
  // always true, so every jaddr-relative branch shares one datapath.
  function automatic branchKind_e decodeKind(input logic [5:0] opcode);
    branchKind_e kind;
    case (opcode)
      OP_B, OP_BZ, OP_BNZ, OP_BCY, OP_BNCY, OP_BV, OP_BS: kind = COND;
      OP_BR:  kind = REG;
      OP_BL:  kind = CALL;
      OP_RET: kind = RETURN;
      default: kind = NONE;
    endcase
    return kind;
  endfunction

  function automatic condSel_e decodeCond(input logic [5:0] opcode);
    condSel_e sel;
    case (opcode)
      OP_B:    sel = COND_ALWAYS;
      OP_BZ:   sel = COND_ZERO;
      OP_BNZ:  sel = COND_NZERO;
      OP_BCY:  sel = COND_CARRY;
      OP_BNCY: sel = COND_NCARRY;
      OP_BV:   sel = COND_OVF;
      OP_BS:   sel = COND_SIGN;
      default: sel = COND_NEVER;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/ras_stack.sv
// ---------------------------------------------------------------------------
// ras_stack
// Circular return-address stack with saturating occupancy count.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   push          write push_data one slot above the current top
//   pop           drop the current top entry (ignored when empty)
//   push_data     address to push
//   top_data      entry at the current top pointer
//   empty         count is zero
//   count         number of valid entries, saturates at RAS_DEPTH
// When full, a push overwrites the oldest entry, which is the slot the
// advancing top pointer lands on, so the count simply stays saturated.
// ---------------------------------------------------------------------------
module ras_stack #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [XLEN-1:0]              push_data,
  output logic [XLEN-1:0]              top_data,
  output logic                         empty,
  output logic [$clog2(RAS_DEPTH):0]   count
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] entries [RAS_DEPTH];
  logic [PW-1:0]   topPtr;
  logic [CW-1:0]   countReg;

  // Push advances the top pointer and writes the new slot; pop retreats it.
  // The pointer wraps naturally because the depth is a power of two. Pop on
  // an empty stack is ignored so a stray pop can never underflow the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      topPtr   <= '0;
      countReg <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else if (push) begin
      entries[topPtr + PW'(1)] <= push_data;
      topPtr                   <= topPtr + PW'(1);
      if (countReg != CW'(RAS_DEPTH)) begin
        countReg <= countReg + CW'(1);
      end
    end else if (pop && (countReg != '0)) begin
      topPtr   <= topPtr - PW'(1);
      countReg <= countReg - CW'(1);
    end
  end

  assign top_data = entries[topPtr];
  assign empty    = (countReg == '0);
  assign count    = countReg;

endmodule

// File: rtl/branch_unit_ras.sv
// ---------------------------------------------------------------------------
// branch_unit_ras
// Registered branch-resolution unit for the KGP_RISC execute stage, with a
// return-address stack that predicts RET targets.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   flush_i                  drop the held result and any incoming instruction
//   in_valid_i / in_ready_o  input handshake
//   opcode_i, rs_i, jaddr_i  instruction fields / register operand
//   carry_i, zero_i,
//   overflow_i, sign_i       ALU flags
//   pc_i                     address of the branch instruction
//   out_valid_o/out_ready_i  output handshake
//   ex_npc_o, pc_src_o       branch target and taken select
//   ra_o, ra_we_o            link address and link-register write enable
//   ras_miss_o               RET found the stack empty
//   ret_mismatch_o           RET prediction differed from rs_i
//   ras_count_o              stack occupancy
// ---------------------------------------------------------------------------
module branch_unit_ras
  import branch_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int JW          = 26,
  parameter int RAS_DEPTH   = 4,
  parameter int LINK_OFFSET = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [5:0]                  opcode_i,
  input  logic [XLEN-1:0]             rs_i,
  input  logic [JW-1:0]               jaddr_i,
  input  logic                        carry_i,
  input  logic                        zero_i,
  input  logic                        overflow_i,
  input  logic                        sign_i,
  input  logic [XLEN-1:0]             pc_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [XLEN-1:0]             ex_npc_o,
  output logic                        pc_src_o,
  output logic [XLEN-1:0]             ra_o,
  output logic                        ra_we_o,
  output logic                        ras_miss_o,
  output logic                        ret_mismatch_o,
  output logic [$clog2(RAS_DEPTH):0]  ras_count_o
);

  branchKind_e     kind;
  condSel_e        condSel;
  logic            condMet;
  logic            accept;
  logic [XLEN-1:0] jaddrExt;
  logic [XLEN-1:0] linkAddr;
  logic [XLEN-1:0] nextNpc;
  logic            nextSrc;
  logic            nextRaWe;
  logic            nextMiss;
  logic            nextMismatch;
  logic            rasPush;
  logic            rasPop;
  logic [XLEN-1:0] rasTop;
  logic            rasEmpty;

  logic            outValid;
  logic [XLEN-1:0] npcReg;
  logic            srcReg;
  logic [XLEN-1:0] raReg;
  logic            raWeReg;
  logic            missReg;
  logic            mismatchReg;

  assign in_ready_o = !outValid || out_ready_i;
  assign accept     = in_valid_i && in_ready_o && !flush_i;
  assign jaddrExt   = {{(XLEN-JW){1'b0}}, jaddr_i};
  assign linkAddr   = pc_i + XLEN'(LINK_OFFSET);

  // Decode the opcode, evaluate its flag condition and build the values that
  // the output register will capture. RAS push/pop are gated by accept so a
  // stalled or flushed instruction never disturbs the stack. A RET that
  // finds the stack empty falls back to rs_i and flags the miss instead.
  always_comb begin
    kind         = decodeKind(opcode_i);
    condSel      = decodeCond(opcode_i);
    condMet      = 1'b0;
    nextNpc      = '0;
    nextSrc      = 1'b0;
    nextRaWe     = 1'b0;
    nextMiss     = 1'b0;
    nextMismatch = 1'b0;
    rasPush      = 1'b0;
    rasPop       = 1'b0;

    case (condSel)
      COND_ALWAYS: condMet = 1'b1;
      COND_ZERO:   condMet = zero_i;
      COND_NZERO:  condMet = !zero_i;
      COND_CARRY:  condMet = carry_i;
      COND_NCARRY: condMet = !carry_i;
      COND_OVF:    condMet = overflow_i;
      COND_SIGN:   condMet = sign_i;
      default:     condMet = 1'b0;
    endcase

    case (kind)
      COND: begin
        nextNpc = jaddrExt;
        nextSrc = condMet;
      end
      REG: begin
        nextNpc = rs_i;
        nextSrc = 1'b1;
      end
      CALL: begin
        nextNpc  = jaddrExt;
        nextSrc  = 1'b1;
        nextRaWe = 1'b1;
        rasPush  = accept;
      end
      RETURN: begin
        nextSrc = 1'b1;
        if (rasEmpty) begin
          nextNpc  = rs_i;
          nextMiss = 1'b1;
        end else begin
          nextNpc      = rasTop;
          nextMismatch = (rasTop != rs_i);
          rasPop       = accept;
        end
      end
      default: begin
        nextNpc = '0;
        nextSrc = 1'b0;
      end
    endcase
  end

  // Output register. A new accept always wins; otherwise flush or a consumer
  // handshake retires the held result. Data fields only change on accept so
  // they stay stable for the whole time a result is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      outValid    <= 1'b0;
      npcReg      <= '0;
      srcReg      <= 1'b0;
      raReg       <= '0;
      raWeReg     <= 1'b0;
      missReg     <= 1'b0;
      mismatchReg <= 1'b0;
    end else if (accept) begin
      outValid    <= 1'b1;
      npcReg      <= nextNpc;
      srcReg      <= nextSrc;
      raReg       <= linkAddr;
      raWeReg     <= nextRaWe;
      missReg     <= nextMiss;
      mismatchReg <= nextMismatch;
    end else if (flush_i || out_ready_i) begin
      outValid <= 1'b0;
    end
  end

  ras_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) uRasStack (
    .clk       (clk),
    .rst       (rst),
    .push      (rasPush),
    .pop       (rasPop),
    .push_data (linkAddr),
    .top_data  (rasTop),
    .empty     (rasEmpty),
    .count     (ras_count_o)
  );

  assign out_valid_o    = outValid;
  assign ex_npc_o       = npcReg;
  assign pc_src_o       = srcReg;
  assign ra_o           = raReg;
  assign ra_we_o        = raWeReg;
  assign ras_miss_o     = missReg;
  assign ret_mismatch_o = mismatchReg;

endmodule

// File: tb/tb_branch_unit_ras.sv
// ---------------------------------------------------------------------------
// tb_branch_unit_ras
// Directed scenarios followed by a randomized run, all checked against a
// queue-based return-stack model and the branch table written out directly.
// ---------------------------------------------------------------------------
module tb_branch_unit_ras;

  localparam int XLEN  = 32;
  localparam int JW    = 26;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst, flush, inValid, outReady;
  logic            inReady, outValid;
  logic [5:0]      opcode;
  logic [XLEN-1:0] rs, pc;
  logic [JW-1:0]   jaddr;
  logic            carry, zero, overflow, sign;
  logic [XLEN-1:0] exNpc, ra;
  logic            pcSrc, raWe, rasMiss, retMismatch;
  logic [2:0]      rasCount;

  int compared   = 0;
  int mismatched = 0;

  logic [XLEN-1:0] rasModel[$];
  logic            expValid;
  logic [XLEN-1:0] expNpc, expRa;
  logic            expSrc, expRaWe, expMiss, expMismatch;

  always #5 clk = ~clk;

  branch_unit_ras #(
    .XLEN(XLEN), .JW(JW), .RAS_DEPTH(DEPTH), .LINK_OFFSET(4)
  ) dut (
    .clk(clk), .rst(rst), .flush_i(flush),
    .in_valid_i(inValid), .in_ready_o(inReady),
    .opcode_i(opcode), .rs_i(rs), .jaddr_i(jaddr),
    .carry_i(carry), .zero_i(zero), .overflow_i(overflow), .sign_i(sign),
    .pc_i(pc), .out_valid_o(outValid), .out_ready_i(outReady),
    .ex_npc_o(exNpc), .pc_src_o(pcSrc), .ra_o(ra), .ra_we_o(raWe),
    .ras_miss_o(rasMiss), .ret_mismatch_o(retMismatch),
    .ras_count_o(rasCount)
  );

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Reference behaviour for one clock edge, taken straight from the branch
  // table; the stack is a plain queue with the newest entry at the back.
  task automatic modelEdge(input logic expReady);
    logic            acc;
    logic [XLEN-1:0] jext, topVal;
    acc  = inValid && expReady && !flush;
    jext = {{(XLEN-JW){1'b0}}, jaddr};
    if (rst) begin
      expValid = 0; expNpc = 0; expSrc = 0; expRa = 0;
      expRaWe = 0; expMiss = 0; expMismatch = 0;
      rasModel.delete();
    end else if (acc) begin
      expValid = 1; expRa = pc + 32'd4; expRaWe = 0;
      expMiss = 0; expMismatch = 0; expNpc = jext; expSrc = 0;
      case (opcode)
        6'b110000: expSrc = 1;
        6'b110001: expSrc = zero;
        6'b110010: expSrc = !zero;
        6'b110011: expSrc = carry;
        6'b110100: expSrc = !carry;
        6'b110101: expSrc = overflow;
        6'b110110: expSrc = sign;
        6'b110111: begin expSrc = 1; expNpc = rs; end
        6'b111001: begin
          expSrc = 1; expRaWe = 1;
          rasModel.push_back(pc + 32'd4);
          if (rasModel.size() > DEPTH) void'(rasModel.pop_front());
        end
        6'b111010: begin
          expSrc = 1;
          if (rasModel.size() > 0) begin
            topVal      = rasModel.pop_back();
            expNpc      = topVal;
            expMismatch = (topVal != rs);
          end else begin
            expNpc  = rs;
            expMiss = 1;
          end
        end
        default: begin expNpc = 0; expSrc = 0; end
      endcase
    end else if (flush || outReady) begin
      expValid = 0;
    end
  endtask

  task automatic checkOutput(input string tag);
    check({tag, ".valid"},    32'(outValid),    32'(expValid));
    check({tag, ".npc"},      exNpc,            expNpc);
    check({tag, ".src"},      32'(pcSrc),       32'(expSrc));
    check({tag, ".ra"},       ra,               expRa);
    check({tag, ".raWe"},     32'(raWe),        32'(expRaWe));
    check({tag, ".miss"},     32'(rasMiss),     32'(expMiss));
    check({tag, ".mismatch"}, 32'(retMismatch), 32'(expMismatch));
    check({tag, ".count"},    32'(rasCount),    32'(rasModel.size()));
  endtask

  // Drive one cycle of inputs, check the ready path before the edge, then
  // advance the model and compare every registered output after the edge.
  task automatic applyStimulus(input string tag, input logic r, input logic f,
                               input logic v, input logic [5:0] op,
                               input logic [XLEN-1:0] rsV, input logic [JW-1:0] ja,
                               input logic [3:0] flags, input logic [XLEN-1:0] pcV,
                               input logic rdy);
    logic expReady;
    rst = r; flush = f; inValid = v; opcode = op; rs = rsV; jaddr = ja;
    {carry, zero, overflow, sign} = flags; pc = pcV; outReady = rdy;
    #1;
    expReady = !expValid || rdy;
    check({tag, ".inReady"}, 32'(inReady), 32'(expReady));
    modelEdge(expReady);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  localparam logic [5:0] B = 6'b110000, BZ = 6'b110001, BCY = 6'b110011;
  localparam logic [5:0] BL = 6'b111001, RET = 6'b111010;

  initial begin
    logic [5:0]      rop;
    logic [XLEN-1:0] rrs;
    int              sel;
    expValid = 0; expNpc = 0; expSrc = 0; expRa = 0;
    expRaWe = 0; expMiss = 0; expMismatch = 0;
    rst = 1; flush = 0; inValid = 0; opcode = 0; rs = 0; jaddr = 0;
    {carry, zero, overflow, sign} = 4'b0; pc = 0; outReady = 1;
    @(posedge clk); #1;

    applyStimulus("reset", 1, 0, 0, 0, 0, 0, 4'b0, 0, 1);

    applyStimulus("bcyTaken", 0, 0, 1, BCY, 0, 26'h0CD7C15, 4'b1000, 32'h80, 1);
    check("bcyTaken.literalNpc", exNpc, 32'h00CD7C15);
    applyStimulus("bcyNotTaken", 0, 0, 1, BCY, 0, 26'h0CD7C15, 4'b0000, 32'h84, 1);
    check("bcyNotTaken.literalSrc", 32'(pcSrc), 32'd0);

    applyStimulus("callBl", 0, 0, 1, BL, 0, 26'h40, 4'b0, 32'h1000, 1);
    check("callBl.literalRa", ra, 32'h1004);
    applyStimulus("callRet", 0, 0, 1, RET, 32'h1004, 0, 4'b0, 32'h2000, 1);
    check("callRet.literalNpc", exNpc, 32'h1004);

    for (int i = 1; i <= 5; i++)
      applyStimulus("wrapBl", 0, 0, 1, BL, 0, 26'h10, 4'b0, 32'(i * 16), 1);
    check("wrapBl.saturated", 32'(rasCount), 32'd4);
    for (int i = 0; i < 5; i++) begin
      applyStimulus("wrapRet", 0, 0, 1, RET, 32'hABC0, 0, 4'b0, 32'h300, 1);
      if (i < 4) check("wrapRet.literalNpc", exNpc, 32'(32'h54 - 32'(i) * 32'h10));
      else       check("wrapRet.literalMiss", 32'(rasMiss), 32'd1);
    end

    applyStimulus("mmBl", 0, 0, 1, BL, 0, 26'h1, 4'b0, 32'h200, 1);
    applyStimulus("mmRet", 0, 0, 1, RET, 32'h300, 0, 4'b0, 32'h500, 1);
    check("mmRet.literalMismatch", 32'(retMismatch), 32'd1);

    applyStimulus("stallBz", 0, 0, 1, BZ, 0, 26'h77, 4'b0100, 32'h600, 1);
    for (int i = 0; i < 3; i++)
      applyStimulus("stallHold", 0, 0, (i == 2), (i == 2) ? BL : B, 0, 26'h5,
                    4'b0, 32'h700, 0);
    applyStimulus("stallRelease", 0, 0, 1, BL, 0, 26'h5, 4'b0, 32'h700, 1);

    applyStimulus("flushBl", 0, 1, 1, BL, 0, 26'h9, 4'b0, 32'h800, 1);
    applyStimulus("holdPre", 0, 0, 1, B, 0, 26'h3, 4'b0, 32'h900, 0);
    applyStimulus("holdMore", 0, 0, 0, B, 0, 26'h3, 4'b0, 32'h900, 0);
    applyStimulus("resetHeld", 1, 0, 0, B, 0, 26'h3, 4'b0, 32'h900, 0);

    for (int n = 0; n < 400; n++) begin
      sel = int'($urandom_range(0, 12));
      if (sel <= 7)       rop = 6'b110000 + 6'(sel);
      else if (sel <= 9)  rop = BL;
      else if (sel <= 11) rop = RET;
      else                rop = 6'($urandom);
      rrs = $urandom;
      if (($urandom_range(0, 1) == 1) && (rasModel.size() > 0)) rrs = rasModel[$];
      applyStimulus("rand", ($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 3) != 0), rop, rrs, 26'($urandom),
                    4'($urandom), $urandom, ($urandom_range(0, 2) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
